apb_master_bridge: RTL
======================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 255, ACCESS-phase wait-cycle limit; used only when APB_MASTER_BRIDGE_TIMEOUT_EN is defined; legal range 1..65535.
REQ-002 Port list, one per line (name  direction  width  meaning); single clock domain, reset synchronous active-high:
  PCLK  in  1  clock; all state updates on rising edge
  PRESET  in  1  synchronous active-high reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  18  word address, bits [19:2]
  cmd_wdata  in  32  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_rdata  out  32  read data
  rsp_err  out  1  transfer error
  PSEL  out  1  APB select
  PADDR  out  18  APB address [19:2]
  PENABLE  out  1  APB access phase
  PWRITE  out  1  APB direction
  PWDATA  out  32  APB write data
  PRDATA  in  32  APB read data
  PREADY  in  1  APB completer ready

Function
REQ-003 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one transfer outstanding at a time.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-005 On acceptance, cmd_addr, cmd_write, cmd_wdata SHALL be latched onto PADDR, PWRITE, PWDATA; PWDATA SHALL be 0 for reads; FSM goes IDLE->SETUP.
REQ-006 SETUP: PSEL=1, PENABLE=0, exactly one cycle; SETUP->ACCESS unconditionally.
REQ-007 ACCESS: PSEL=1, PENABLE=1; held while PREADY=0; on a PREADY=1 edge, transfer completes, FSM goes ACCESS->RESP.
REQ-008 At completion, rsp_rdata SHALL capture PRDATA for reads and load 0 for writes; rsp_err SHALL be 0.
REQ-009 PADDR, PWRITE, PWDATA SHALL stay constant from SETUP through the final ACCESS cycle; after completion they hold their last value.
REQ-010 PSEL=0 and PENABLE=0 in IDLE and RESP.
REQ-011 RESP: rsp_valid=1; rsp_rdata and rsp_err stable until an rsp_valid&rsp_ready edge, then RESP->IDLE.
REQ-012 Minimum latency with PREADY=1 and rsp_ready=1: accept at edge 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, cmd_ready again cycle 4.
REQ-013 PRDATA is sampled only on the completing ACCESS edge; PREADY outside ACCESS is ignored.
REQ-014 cmd_* inputs are ignored outside IDLE; command changes do not affect an in-flight transfer.

Reset
REQ-015 PRESET=1 at an edge SHALL force IDLE with cmd_ready=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the timeout counter at 0.
REQ-016 Reset in SETUP, ACCESS or RESP SHALL abandon the transfer: no response produced, PSEL drops on that edge.
REQ-017 Reset takes priority over all handshakes in the same cycle.

Configuration
REQ-018 Macro APB_MASTER_BRIDGE_TIMEOUT_EN defined: a wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT with PREADY still 0, the transfer SHALL terminate to RESP with rsp_err=1, rsp_rdata=32'hDEADBEEF, PSEL=PENABLE=0 from the next cycle.
REQ-019 PREADY=1 in the same cycle the count reaches TIMEOUT SHALL count as normal completion with rsp_err=0.
REQ-020 Macro undefined: no counter logic; ACCESS waits indefinitely; rsp_err is constant 0.

Verification
REQ-021 Write addr 18'h4, data 32'h1234_5678, PREADY=1 -> PSEL cycle 1, PENABLE cycle 2, PWDATA=32'h12345678, rsp_valid cycle 3, rsp_rdata=0, rsp_err=0.
REQ-022 Read addr 18'h8, PREADY low 3 ACCESS cycles, PRDATA=32'h0000_0001 on completion -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=32'h1.
REQ-023 Back-to-back commands, rsp_ready held 0 for 5 cycles -> cmd_ready stays 0, PSEL stays 0, rsp_rdata stable until rsp_ready=1.
REQ-024 PRESET pulsed during ACCESS with PREADY=0 -> PSEL=0 next cycle, rsp_valid never asserts, cmd_ready=1.
REQ-025 With TIMEOUT_EN, TIMEOUT=4, PREADY stuck 0 -> after 4 wait cycles, rsp_err=1, rsp_rdata=32'hDEADBEEF; repeat with PREADY=1 on the 4th cycle -> rsp_err=0.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bundle for the APB master bridge: command/response handshakes and the APB bus.
// master = the bridge itself, slave = the command source, response sink and APB completer.
interface apb_master_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic [17:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        input  rsp_ready,
        input  PRDATA,
        input  PREADY,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output PSEL,
        output PADDR,
        output PENABLE,
        output PWRITE,
        output PWDATA
    );

    modport slave (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        output rsp_ready,
        output PRDATA,
        output PREADY,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  PSEL,
        input  PADDR,
        input  PENABLE,
        input  PWRITE,
        input  PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge (IDLE/SETUP/ACCESS/RESP).
// Optional ACCESS wait timeout enabled by defining APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_master_bridge_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT must be within 1..65535");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [17:0] r_paddr;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_done;
    logic        w_abort;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_done   = (r_state == S_ACCESS) && bus.PREADY;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_CNT = 16'(TIMEOUT);

    logic [15:0] r_cnt;
    logic        r_err;
    logic        w_hit;

    assign w_hit   = (r_cnt + 16'd1) == TMO_CNT;
    assign w_abort = (r_state == S_ACCESS) && !bus.PREADY && w_hit;

    // Wait counter: cleared while entering ACCESS, counts stalled ACCESS cycles
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= 16'd0;
        end else if ((r_state == S_ACCESS) && !bus.PREADY) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Error flag: set only by a timed-out transfer, cleared by a normal one
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_err <= 1'b0;
        end else if (w_done) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign bus.rsp_err = r_err;
`else
    assign w_abort     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state selection for the single outstanding transfer
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY || w_abort) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture: only an accepted command touches the APB request fields
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr  <= 18'd0;
            r_pwrite <= 1'b0;
            r_pwdata <= 32'd0;
        end else if (w_accept) begin
            r_paddr  <= bus.cmd_addr;
            r_pwrite <= bus.cmd_write;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
        end
    end

    // Response data: PRDATA sampled only on the completing ACCESS edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rdata <= 32'd0;
        end else if (w_done) begin
            r_rdata <= r_pwrite ? 32'd0 : bus.PRDATA;
        end else if (w_abort) begin
            r_rdata <= TMO_DATA;
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign bus.PENABLE   = (r_state == S_ACCESS);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.PADDR     = r_paddr;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_rdata = r_rdata;

endmodule
